// File: rtl/aes_byte_stream_if.sv
// Byte-wide valid/ready streams between the byte source/sink and aes_byte_stream.
interface aes_byte_stream_if;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_byte, in_valid, out_ready,
    input  in_ready, out_byte, out_valid
  );

  modport slave (
    input  in_byte, in_valid, out_ready,
    output in_ready, out_byte, out_valid
  );
endinterface

// File: rtl/aes_byte_stream.sv
// Byte-serial front end for a fixed-latency AES-128 core: gathers key and
// plaintext bytes, launches the core, then streams the 16-byte result back out.
module aes_byte_stream #(
  parameter int LATENCY = 11
) (
  input  logic             clk,
  input  logic             reset,
  aes_byte_stream_if.slave stream,
  output logic [0:127]     core_key,
  output logic [0:127]     core_data,
  output logic             core_start,
  input  logic [0:127]     core_result,
  output logic             busy,
  output logic [7:0]       block_count
);

  typedef enum logic [2:0] {LOAD_KEY, LOAD_DATA, START, WAIT, SEND} state_t;

  state_t       state, state_next;
  logic [3:0]   idx;
  logic [7:0]   wait_cnt;
  logic [0:127] capture;
  logic         in_xfer, out_xfer, last_byte, wait_done;

  assign last_byte = (idx == 4'd15);
  assign wait_done = (wait_cnt == 8'(LATENCY - 1));
  assign stream.out_byte = capture[{idx, 3'b000} +: 8];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD_KEY;
    else        state <= state_next;
  end

  // Handshake qualifiers come straight from the registered state, so ready and
  // valid never depend combinationally on the other side's valid/ready.
  always_comb begin
    state_next       = state;
    stream.in_ready  = 1'b0;
    stream.out_valid = 1'b0;
    core_start       = 1'b0;
    busy             = 1'b1;
    in_xfer          = 1'b0;
    out_xfer         = 1'b0;
    case (state)
      LOAD_KEY: begin
        stream.in_ready = 1'b1;
        in_xfer         = stream.in_valid;
        busy            = (idx != 4'd0);
        if (in_xfer && last_byte) state_next = LOAD_DATA;
      end
      LOAD_DATA: begin
        stream.in_ready = 1'b1;
        in_xfer         = stream.in_valid;
        if (in_xfer && last_byte) state_next = START;
      end
      START: begin
        core_start = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (wait_done) state_next = SEND;
      end
      SEND: begin
        stream.out_valid = 1'b1;
        out_xfer         = stream.out_ready;
        if (out_xfer && last_byte) state_next = LOAD_KEY;
      end
      default: state_next = LOAD_KEY;
    endcase
  end

  // One shared byte index serves all three 16-byte phases; it wraps to 0
  // exactly when each phase completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx         <= 4'd0;
      wait_cnt    <= 8'd0;
      core_key    <= '0;
      core_data   <= '0;
      capture     <= '0;
      block_count <= 8'd0;
    end else begin
      if (in_xfer || out_xfer) idx <= idx + 4'd1;
      if (in_xfer && state == LOAD_KEY)  core_key[{idx, 3'b000} +: 8]  <= stream.in_byte;
      if (in_xfer && state == LOAD_DATA) core_data[{idx, 3'b000} +: 8] <= stream.in_byte;
      if (state == WAIT) wait_cnt <= wait_cnt + 8'd1;
      else               wait_cnt <= 8'd0;
      if (state == WAIT && wait_done) capture <= core_result;
      if (out_xfer && last_byte) block_count <= block_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_aes_byte_stream.sv
// Self-checking bench for aes_byte_stream with a behavioural fixed-latency core model.
module tb_aes_byte_stream;

  localparam int L = 11;
  localparam logic [0:127] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         reset;
  logic [0:127] core_key, core_data, core_result;
  logic         core_start, busy;
  logic [7:0]   block_count;
  logic [7:0]   exp_blocks;
  int           tests = 0;
  int           fails = 0;

  aes_byte_stream_if bus();

  aes_byte_stream #(.LATENCY(L)) dut (
    .clk(clk), .reset(reset), .stream(bus),
    .core_key(core_key), .core_data(core_data), .core_start(core_start),
    .core_result(core_result), .busy(busy), .block_count(block_count)
  );

  always #5 clk = ~clk;

  function automatic logic [0:127] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stand-in for the AES core: the known FIPS answer, otherwise a keyed scramble.
  function automatic logic [0:127] core_fn(input logic [0:127] k, input logic [0:127] d);
    if (k == FIPS_KEY && d == FIPS_PT) return FIPS_CT;
    return k ^ {d[64:127], d[0:63]} ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
  endfunction

  // Result is valid only in the single cycle the front end is supposed to sample it.
  initial begin
    logic [0:127] k, d;
    core_result = rand128();
    forever begin
      @(negedge clk);
      if (core_start === 1'b1) begin
        k = core_key;
        d = core_data;
        repeat (L) @(posedge clk);
        #1 core_result = core_fn(k, d);
        @(posedge clk);
        #1 core_result = rand128();
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_reset_values();
    check_output("rst_out_valid", bus.out_valid, 1'b0);
    check_output("rst_core_start", core_start, 1'b0);
    check_output("rst_core_key", core_key, '0);
    check_output("rst_core_data", core_data, '0);
    check_output("rst_out_byte", bus.out_byte, 8'h00);
    check_output("rst_block_count", block_count, 8'h00);
    check_output("rst_busy", busy, 1'b0);
  endtask

  // in_mode: 0 back-to-back, 1 toggling gaps, 2 random gaps.
  // out_mode: 0 always ready, 1 random stalls, 2 five-cycle stall on byte 3.
  task automatic apply_stimulus(input logic [0:127] key, input logic [0:127] data,
                                input int in_mode, input int out_mode,
                                input bit hold_aa, input int start_idx);
    logic [0:127] exp;
    int sent, got, stall;
    bit v, r;
    exp   = core_fn(key, data);
    sent  = start_idx;
    v     = 1'b0;
    while (sent < 32) begin
      @(negedge clk);
      check_output("in_ready_load", bus.in_ready, 1'b1);
      check_output("busy_load", busy, (sent != 0));
      if (in_mode == 0)      v = 1'b1;
      else if (in_mode == 1) v = ~v;
      else                   v = 1'($urandom_range(0, 1));
      bus.in_valid = v;
      if (!v)             bus.in_byte = 8'($urandom);
      else if (sent < 16) bus.in_byte = key[sent*8 +: 8];
      else                bus.in_byte = data[(sent-16)*8 +: 8];
      if (v) sent++;
    end
    @(negedge clk);
    bus.in_valid = hold_aa;
    bus.in_byte  = 8'haa;
    check_output("core_start_pulse", core_start, 1'b1);
    check_output("core_key", core_key, key);
    check_output("core_data", core_data, data);
    check_output("in_ready_start", bus.in_ready, 1'b0);
    for (int c = 0; c < L; c++) begin
      @(negedge clk);
      check_output("core_start_low", core_start, 1'b0);
      check_output("out_valid_wait", bus.out_valid, 1'b0);
      check_output("in_ready_wait", bus.in_ready, 1'b0);
      check_output("core_key_stable", core_key, key);
    end
    got   = 0;
    stall = 0;
    while (got < 16) begin
      @(negedge clk);
      check_output("out_valid_send", bus.out_valid, 1'b1);
      check_output("out_byte", bus.out_byte, exp[got*8 +: 8]);
      check_output("in_ready_send", bus.in_ready, 1'b0);
      check_output("core_key_send", core_key, key);
      if (out_mode == 0)                  r = 1'b1;
      else if (out_mode == 1)             r = ($urandom_range(0, 2) != 0);
      else if (got == 3 && stall < 5) begin r = 1'b0; stall++; end
      else                                r = 1'b1;
      bus.out_ready = r;
      if (r) got++;
    end
    exp_blocks = exp_blocks + 8'd1;
    @(negedge clk);
    bus.out_ready = 1'($urandom_range(0, 1));
    check_output("out_valid_done", bus.out_valid, 1'b0);
    check_output("in_ready_done", bus.in_ready, 1'b1);
    check_output("block_count", block_count, exp_blocks);
    check_output("busy_idle", busy, 1'b0);
    if (hold_aa) begin
      @(posedge clk);
      #1;
      check_output("aa_key_byte0", core_key, {8'haa, key[8:127]});
      check_output("busy_after_aa", busy, 1'b1);
    end
  endtask

  initial begin
    logic [0:127] k, d;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_byte   = 8'h00;
    bus.out_ready = 1'b0;
    exp_blocks    = 8'd0;
    #1;
    check_reset_values();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    $display("[TB] nominal FIPS-197 vector");
    apply_stimulus(FIPS_KEY, FIPS_PT, 0, 0, 1'b0, 0);
    check_output("block_count_one", block_count, 8'd1);

    $display("[TB] input gaps");
    apply_stimulus(FIPS_KEY, FIPS_PT, 1, 0, 1'b0, 0);

    $display("[TB] output backpressure");
    apply_stimulus(FIPS_KEY, FIPS_PT, 0, 2, 1'b0, 0);

    $display("[TB] input stall during WAIT/SEND");
    apply_stimulus(FIPS_KEY, FIPS_PT, 0, 0, 1'b1, 0);
    k = rand128();
    k[0:7] = 8'haa;
    apply_stimulus(k, rand128(), 0, 0, 1'b0, 1);

    $display("[TB] randomized blocks");
    for (int i = 0; i < 6; i++) begin
      k = rand128();
      d = rand128();
      apply_stimulus(k, d, 2, 1, 1'b0, 0);
    end

    $display("[TB] reset mid-load");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_byte  = 8'($urandom);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset        = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    reset      = 1'b1;
    exp_blocks = 8'd0;
    apply_stimulus(FIPS_KEY, FIPS_PT, 0, 0, 1'b0, 0);
    check_output("block_count_after_reset", block_count, 8'd1);

    $display("[TB] block counter wrap");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset      = 1'b1;
    exp_blocks = 8'd0;
    for (int b = 1; b <= 256; b++) begin
      k = rand128();
      d = rand128();
      apply_stimulus(k, d, 0, 0, 1'b0, 0);
      if (b == 255) check_output("block_count_255", block_count, 8'd255);
      if (b == 256) check_output("block_count_wrap", block_count, 8'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_byte_stream.md
# aes_byte_stream

Byte-serial front end for the 128-bit AES-128 encryption core. It collects a 16-byte key and a 16-byte plaintext block from an 8-bit valid/ready input stream and launches the core with a one-cycle start pulse. It waits the core's fixed latency, captures the 128-bit result and returns it as 16 bytes on an 8-bit valid/ready output stream. The core stays a fixed-latency, no-handshake unit; this block owns all sequencing.

## Interface

- LATENCY, 11, cycles from `core_start` high to `core_result` valid; legal range 1..255.

- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- in_byte  in  8  input byte
- in_valid  in  1  `in_byte` valid
- in_ready  out  1  block can accept a byte this cycle
- out_byte  out  8  output byte
- out_valid  out  1  `out_byte` valid
- out_ready  in  1  sink accepts `out_byte` this cycle
- core_key  out  128  assembled key, bit 0 = MSB of byte 0
- core_data  out  128  assembled plaintext, same ordering
- core_start  out  1  one-cycle launch pulse to the core
- core_result  in  128  core output, sampled once
- busy  out  1  high unless in LOAD_KEY with byte index 0
- block_count  out  8  completed blocks, modulo 256

## Operation

- FSM states, in order:
  - LOAD_KEY: in_ready=1; 16 accepted bytes fill `core_key[0:7]` first, `[120:127]` last.
  - LOAD_DATA: in_ready=1; 16 bytes fill `core_data` in the same order.
  - START: core_start=1 for exactly one cycle.
  - WAIT: counts LATENCY cycles.
  - SEND: out_valid=1 for 16 bytes from the capture register, byte 0 (bits [0:7]) first.
- A transaction is always 32 input bytes: 16 key bytes, then 16 data bytes. There is no key-reuse mode.
- Input handshake:
  - A byte transfers on a rising edge with in_valid=1 and in_ready=1.
  - A 4-bit index increments per transfer and wraps 15→0 on the state change.
- Output handshake:
  - A byte transfers on a rising edge with out_valid=1 and out_ready=1.
  - While out_valid=1 and out_ready=0, `out_byte` is held stable.
- Transitions:
  - LOAD_KEY→LOAD_DATA on the 16th key transfer.
  - LOAD_DATA→START on the 16th data transfer.
  - START→WAIT unconditionally.
  - WAIT→SEND when the counter reaches LATENCY; `core_result` is captured on that edge.
  - SEND→LOAD_KEY on the 16th output transfer; `block_count` increments on that same edge.
- `core_key` and `core_data` change only on input transfers. They are stable from START until the next transaction's first input byte.
- in_ready=0 in START, WAIT and SEND. Input bytes offered then are not consumed.
- in_valid and out_ready are ignored in states where they are irrelevant. They have no side effects.
- `block_count` wraps from 255 to 0.
- The WAIT counter is 8 bits wide. It resets to 0 on entry to WAIT.

## Timing

- Reset (reset=0), any state, asynchronous:
  - state=LOAD_KEY, indices=0, WAIT counter=0.
  - in_ready=1 once reset is released; out_valid=0, core_start=0.
  - core_key=0, core_data=0, capture register=0, out_byte=0.
  - block_count=0, busy=0.
  - A partial transaction is discarded.
- Let T be the edge of the 16th data transfer:
  - core_start is high in cycle T+1.
  - `core_result` is sampled at the end of cycle T+1+LATENCY.
  - out_valid=1 with byte 0 from cycle T+2+LATENCY.
- With out_ready held at 1, the 16 output bytes occupy 16 consecutive cycles.
- in_ready=1 in the cycle after the 16th output transfer.
- Minimum period per block with no stalls: 32 + 1 + LATENCY + 16 cycles.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Test plan

- Nominal FIPS-197 vector:
  - Stimulus: key bytes 00..0f, then data 00112233445566778899aabbccddeeff, back-to-back; bench core model returns 69c4e0d86a7b0430d8cdb78070b4c55a after LATENCY=11.
  - Required: core_key=000102030405060708090a0b0c0d0e0f; core_start high exactly one cycle, one cycle after the 32nd transfer; out bytes 69,c4,e0,d8,…,c5,5a on 16 consecutive cycles; block_count=1.
- Input gaps:
  - Stimulus: in_valid toggling 1/0 every cycle with the same 32 bytes.
  - Required: identical core_key/core_data and output; no byte dropped or duplicated.
- Output backpressure:
  - Stimulus: out_ready=0 for 5 cycles while byte 3 is presented.
  - Required: out_byte=d8 and out_valid=1 held throughout; next byte 6a follows after out_ready=1.
- Input stall during WAIT/SEND:
  - Stimulus: in_valid=1 with byte aa throughout WAIT and SEND.
  - Required: in_ready=0 and core_key unchanged until SEND ends; aa is accepted as key byte 0 on the first cycle after the 16th output transfer.
- Reset mid-load:
  - Stimulus: assert reset after 20 input bytes, then run a full nominal transaction.
  - Required: all outputs at reset values during reset; correct 69c4…5a output afterwards; block_count=1.
- Counter wrap:
  - Stimulus: 256 complete blocks.
  - Required: block_count reads 255 after block 255 and 0 after block 256.
